alu_control_pipe: RTL and testbench

Pipelined, parameterised ALU control stage for the RV32 datapath: decodes `alu_op` plus `funct3`/`funct7` bits into an `OP_W`-bit ALU operation code for the full RV32I ALU set. The code is held in an output register behind a valid/ready handshake. It optionally sequences multi-cycle M-extension operations, holding the result back for a fixed per-class latency. It sits between the main decoder and the execute stage and replaces the purely combinational 4-bit ALU control used for the ADD/SUB/AND/OR subset.

---
 rtl/alu_control_pipe.sv | 158 +++++++++++++++
 tb/tb_alu_control_pipe.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_pipe.sv
// rtl/alu_control_pipe.sv - registered RV32I ALU control stage with valid/ready handshake; M-extension sequencing under ALU_CTRL_MDU_EN
module alu_control_pipe #(
  parameter int OP_W       = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OP_W-1:0] op,
  output logic            is_mdu,
  output logic            mdu_busy
);

  // ALU operation codes (low four bits; zero-extended to OP_W)
  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_XOR  = 4'b0011;
  localparam logic [3:0] C_SLL  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SRA  = 4'b0111;
  localparam logic [3:0] C_SLT  = 4'b1000;
  localparam logic [3:0] C_SLTU = 4'b1001;

  // The RUN counter must hold the longer of the two latencies minus one
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_VALID = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_valid;
  logic              r_is_mdu;
  logic              r_busy;
  logic [OP_W-1:0]   r_op;
  logic [CNT_W-1:0]  r_cnt;

  logic [3:0]        w_base;
  logic              w_m_sel;
  logic [4:0]        w_code5;
  logic [OP_W-1:0]   w_dec_op;
  logic [CNT_W-1:0]  w_load_cnt;
  logic              w_accept;

`ifdef ALU_CTRL_MDU_EN
  // M-extension ops are R-type with instr[25] set
  assign w_m_sel = (alu_op == 2'b10) && funct7_0;
`else
  // Without the multiply/divide unit instr[25] carries no meaning here
  assign w_m_sel = 1'b0 & funct7_0;
`endif

  // Decode alu_op/funct bits into the base ALU code
  always_comb begin
    w_base = C_ADD;
    case (alu_op)
      2'b00: w_base = C_ADD;
      2'b01: w_base = C_SUB;
      default: begin
        case (funct3)
          3'b000: w_base = ((alu_op == 2'b10) && funct7_5) ? C_SUB : C_ADD;
          3'b001: w_base = C_SLL;
          3'b010: w_base = C_SLT;
          3'b011: w_base = C_SLTU;
          3'b100: w_base = C_XOR;
          3'b101: w_base = funct7_5 ? C_SRA : C_SRL;
          3'b110: w_base = C_OR;
          default: w_base = C_AND;
        endcase
      end
    endcase
  end

  // M ops carry funct3 verbatim under a leading 1 in bit 4
  assign w_code5    = w_m_sel ? {2'b10, funct3} : {1'b0, w_base};
  assign w_dec_op   = OP_W'(w_code5);
  assign w_load_cnt = funct3[2] ? DIV_LOAD : MUL_LOAD;

  // Ready whenever idle, or when the held op leaves this same cycle
  assign in_ready = (r_state == ST_IDLE) || ((r_state == ST_VALID) && out_ready);
  assign w_accept = in_valid && in_ready;

  // Control FSM: load, hold under back-pressure, count multi-cycle ops, flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_is_mdu <= 1'b0;
      r_busy   <= 1'b0;
      r_op     <= '0;
      r_cnt    <= '0;
    end else if (flush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_VALID: begin
          if (w_accept) begin
            r_op     <= w_dec_op;
            r_is_mdu <= w_m_sel;
            if (w_m_sel) begin
              r_state <= ST_RUN;
              r_valid <= 1'b0;
              r_busy  <= 1'b1;
              r_cnt   <= w_load_cnt;
            end else begin
              r_state <= ST_VALID;
              r_valid <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else if ((r_state == ST_VALID) && out_ready) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        end
        ST_RUN: begin
          if (r_cnt == '0) begin
            r_state <= ST_VALID;
            r_valid <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign out_valid = r_valid;
  assign op        = r_op;
  assign is_mdu    = r_is_mdu;
  assign mdu_busy  = r_busy;

endmodule

// File: tb/tb_alu_control_pipe.sv
// tb/tb_alu_control_pipe.sv - self-checking bench for alu_control_pipe
module tb_alu_control_pipe;

  localparam int OP_W = 5;
  localparam int MUL_C = 4;
  localparam int DIV_C = 33;
`ifdef ALU_CTRL_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, funct7_5, funct7_0;
  logic out_valid, out_ready, is_mdu, mdu_busy;
  logic [1:0] alu_op;
  logic [2:0] funct3;
  logic [OP_W-1:0] op;

  int vectors = 0;
  int miscompares = 0;

  // model state: pending op and cycles left before it becomes visible
  bit m_has = 0;
  bit m_mdu = 0;
  int m_op = 0;
  int m_left = 0;

  always #5 clk = ~clk;

  alu_control_pipe #(.OP_W(OP_W), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .out_valid(out_valid), .out_ready(out_ready), .op(op), .is_mdu(is_mdu),
    .mdu_busy(mdu_busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_is_m(input int a, input bit f70);
    return MDU && (a == 2) && f70;
  endfunction

  // Expected code straight from the decode list
  function automatic int ref_op(input int a, input int f3, input bit f75, input bit f70);
    if (ref_is_m(a, f70)) return 16 + f3;
    if (a == 0) return 2;
    if (a == 1) return 6;
    case (f3)
      0: return (a == 2 && f75) ? 6 : 2;
      1: return 4;
      2: return 8;
      3: return 9;
      4: return 3;
      5: return f75 ? 7 : 5;
      6: return 1;
      default: return 0;
    endcase
  endfunction

  // Model update at each edge, then compare every cycle
  always @(posedge clk) begin
    bit vis, rdy, acc;
    if (rst) begin
      m_has = 0; m_mdu = 0; m_op = 0; m_left = 0;
    end else if (flush) begin
      m_has = 0;
    end else begin
      vis = m_has && (m_left == 0);
      rdy = !m_has || (vis && out_ready);
      acc = in_valid && rdy;
      if (vis && out_ready) m_has = 0;
      else if (m_has && m_left > 0) m_left--;
      if (acc) begin
        m_has  = 1;
        m_mdu  = ref_is_m(alu_op, funct7_0);
        m_op   = ref_op(alu_op, funct3, funct7_5, funct7_0);
        m_left = m_mdu ? (funct3[2] ? DIV_C : MUL_C) : 0;
      end
    end
    #1;
    chk("out_valid", out_valid, int'(m_has && m_left == 0));
    chk("mdu_busy", mdu_busy, int'(m_has && m_left > 0));
    chk("in_ready", in_ready, int'(!m_has || (m_left == 0 && out_ready)));
    if (m_has && m_left == 0) begin
      chk("op", op, m_op);
      chk("is_mdu", is_mdu, int'(m_mdu));
    end
  end

  task automatic send(input logic [1:0] a, input logic [2:0] f3, input logic f75, input logic f70);
    int n;
    alu_op = a; funct3 = f3; funct7_5 = f75; funct7_0 = f70; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_wait", int'(n < 200), 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_mdu(input logic [2:0] f3, input int exp_cyc, input int exp_op, input string nm);
    int cnt;
    bit bad;
    send(2'b10, f3, 1'b0, 1'b1);
    cnt = 0; bad = 0;
    while (mdu_busy && cnt < 100) begin
      bad |= in_ready;
      cnt++;
      @(negedge clk);
    end
    chk({nm, "_busy_cycles"}, cnt, exp_cyc);
    chk({nm, "_in_ready_low"}, int'(bad), 0);
    chk({nm, "_op"}, op, exp_op);
    chk({nm, "_is_mdu"}, is_mdu, 1);
    chk({nm, "_out_valid"}, out_valid, 1);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct3 = 3'b000; funct7_5 = 1'b0; funct7_0 = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_op", op, 0);
    chk("rst_mdu_busy", mdu_busy, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // R-type SUB, single pulse
    send(2'b10, 3'b000, 1'b1, 1'b0);
    chk("first_sub_op", op, 5'b00110);
    chk("first_out_valid", out_valid, 1);
    @(negedge clk);
    chk("first_valid_drop", out_valid, 0);

    // Full decode sweep, back-to-back
    for (int a = 0; a < 4; a++)
      for (int f = 0; f < 8; f++)
        for (int s = 0; s < 4; s++)
          send(a[1:0], f[2:0], s[0], s[1]);
    @(negedge clk);

    // I-type funct3 000 ignores funct7_5
    send(2'b11, 3'b000, 1'b1, 1'b0);
    chk("itype_add_op", op, 5'b00010);
    send(2'b10, 3'b101, 1'b1, 1'b0);
    chk("sra_op", op, 5'b00111);
    @(negedge clk);

    // Back-pressure hold, then no-bubble reload
    out_ready = 1'b0;
    send(2'b01, 3'b111, 1'b1, 1'b0);
    alu_op = 2'b10; funct3 = 3'b100; funct7_5 = 1'b0; funct7_0 = 1'b0; in_valid = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("hold_in_ready", in_ready, 0);
      chk("hold_op", op, 5'b00110);
      chk("hold_out_valid", out_valid, 1);
      @(negedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_op", op, 5'b00011);
    chk("b2b_out_valid", out_valid, 1);
    @(negedge clk);
    chk("b2b_drain", out_valid, 0);

    // Asynchronous reset while holding in VALID
    out_ready = 1'b0;
    send(2'b11, 3'b100, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid_out_valid", out_valid, 0);
    chk("arst_valid_op", op, 0);
    chk("arst_valid_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send(2'b00, 3'b101, 1'b1, 1'b1);
    chk("post_arst_op", op, 5'b00010);
    chk("post_arst_valid", out_valid, 1);
    @(negedge clk);

`ifdef ALU_CTRL_MDU_EN
    run_mdu(3'b100, DIV_C, 5'b10100, "div");
    run_mdu(3'b000, MUL_C, 5'b10000, "mul");
    @(negedge clk);

    // Flush on the tenth RUN cycle of a REM
    send(2'b10, 3'b110, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    in_valid = 1'b1; alu_op = 2'b00;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", mdu_busy, 0);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("flush_never_valid", int'(seen), 0);

    // Asynchronous reset mid-RUN
    send(2'b10, 3'b001, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_run_busy", mdu_busy, 0);
    chk("arst_run_is_mdu", is_mdu, 0);
    chk("arst_run_op", op, 0);
    chk("arst_run_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    send(2'b10, 3'b110, 1'b0, 1'b0);
    chk("post_run_arst_op", op, 5'b00001);
    chk("post_run_arst_valid", out_valid, 1);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
